// File: rtl/prepare_for_fft_if.sv
// Frame bus for the FFT input permutation stage: the sample frame and index table go in,
// and the registered permuted frame with its table-error flags comes out.
interface prepare_for_fft_if #(
    parameter int SAMPLES = 2,
    parameter int WIDTH   = 3
);
    localparam int IW = $clog2(SAMPLES);

    logic             in_valid;
    logic [WIDTH-1:0] input_stream  [SAMPLES];
    logic [IW-1:0]    new_indices   [SAMPLES];
    logic             out_valid;
    logic [WIDTH-1:0] output_stream [SAMPLES];
    logic             idx_range_err;
    logic             idx_perm_err;

    modport master (
        output in_valid, input_stream, new_indices,
        input  out_valid, output_stream, idx_range_err, idx_perm_err
    );

    modport slave (
        input  in_valid, input_stream, new_indices,
        output out_valid, output_stream, idx_range_err, idx_perm_err
    );
endinterface

// File: rtl/prepare_for_fft.sv
// Registered gather stage ahead of the FFT butterflies: output_stream[k] = input_stream[new_indices[k]].
// Flags index tables that are out of range or that are not a permutation.
module prepare_for_fft #(
    parameter int SAMPLES = 2,
    parameter int WIDTH   = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    prepare_for_fft_if.slave       bus
);
    localparam int IW = $clog2(SAMPLES);

    logic [WIDTH-1:0] w_gather [SAMPLES];
    logic [SAMPLES-1:0] w_seen;
    logic             w_range_err;
    logic             w_perm_err;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_output_stream [SAMPLES];
    logic             r_idx_range_err;
    logic             r_idx_perm_err;

    // One mux per output slot. The "seen" vector marks every in-range source that has
    // already been claimed, so a second claim on the same source raises the duplicate flag.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
        w_seen      = '0;
        w_range_err = 1'b0;
        w_perm_err  = 1'b0;
        for (int k = 0; k < SAMPLES; k++) begin
            w_gather[k] = '0;
            if (32'(bus.new_indices[k]) < SAMPLES) begin
                w_gather[k] = bus.input_stream[bus.new_indices[k]];
                if (w_seen[bus.new_indices[k]]) begin
                    w_perm_err = 1'b1;
                end
                // NOTE: blocking assignment, because later iterations of this loop must see the update.
                w_seen[bus.new_indices[k]] = 1'b1;
            end else begin
                w_range_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the output array is a handful of flops rather than a RAM, so it takes a reset like any other register.
            r_out_valid     <= 1'b0;
            r_output_stream <= '{default: '0};
            r_idx_range_err <= 1'b0;
            r_idx_perm_err  <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            // Data and flags hold between accepted beats; only out_valid drops.
            if (bus.in_valid) begin
                r_output_stream <= w_gather;
                r_idx_range_err <= w_range_err;
                r_idx_perm_err  <= w_perm_err;
            end
        end
    end

    assign bus.out_valid     = r_out_valid;
    assign bus.output_stream = r_output_stream;
    assign bus.idx_range_err = r_idx_range_err;
    assign bus.idx_perm_err  = r_idx_perm_err;
endmodule

// File: tb/tb_prepare_for_fft.sv
// Directed bench for prepare_for_fft: four instances (SAMPLES = 2, 8, 4, 6) driven with
// hand-computed vectors covering reset, identity, swap, bit-reversal, duplicates, range and streaming.
module tb_prepare_for_fft;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    prepare_for_fft_if #(.SAMPLES(2), .WIDTH(3)) if2 ();
    prepare_for_fft_if #(.SAMPLES(8), .WIDTH(8)) if8 ();
    prepare_for_fft_if #(.SAMPLES(4), .WIDTH(4)) if4 ();
    prepare_for_fft_if #(.SAMPLES(6), .WIDTH(4)) if6 ();

    prepare_for_fft #(.SAMPLES(2), .WIDTH(3)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    prepare_for_fft #(.SAMPLES(8), .WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    prepare_for_fft #(.SAMPLES(4), .WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    prepare_for_fft #(.SAMPLES(6), .WIDTH(4)) u_dut6 (.clk(clk), .rst_n(rst_n), .bus(if6));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_v2"}, 32'(if2.out_valid), 0);
        check({tag, "_v8"}, 32'(if8.out_valid), 0);
        check({tag, "_v4"}, 32'(if4.out_valid), 0);
        check({tag, "_v6"}, 32'(if6.out_valid), 0);
        check({tag, "_flags"}, 32'({if2.idx_range_err, if2.idx_perm_err, if8.idx_range_err, if8.idx_perm_err,
                                   if4.idx_range_err, if4.idx_perm_err, if6.idx_range_err, if6.idx_perm_err}), 0);
        for (int k = 0; k < 2; k++) check($sformatf("%s_d2_%0d", tag, k), 32'(if2.output_stream[k]), 0);
        for (int k = 0; k < 8; k++) check($sformatf("%s_d8_%0d", tag, k), 32'(if8.output_stream[k]), 0);
        for (int k = 0; k < 4; k++) check($sformatf("%s_d4_%0d", tag, k), 32'(if4.output_stream[k]), 0);
        for (int k = 0; k < 6; k++) check($sformatf("%s_d6_%0d", tag, k), 32'(if6.output_stream[k]), 0);
    endtask

    task automatic randomize_inputs();
        if2.in_valid = 1'b1; if8.in_valid = 1'b1; if4.in_valid = 1'b1; if6.in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if2.input_stream[k] = 3'($urandom); if2.new_indices[k] = 1'($urandom);
        end
        for (int k = 0; k < 8; k++) begin
            if8.input_stream[k] = 8'($urandom); if8.new_indices[k] = 3'($urandom);
        end
        for (int k = 0; k < 4; k++) begin
            if4.input_stream[k] = 4'($urandom); if4.new_indices[k] = 2'($urandom);
        end
        for (int k = 0; k < 6; k++) begin
            if6.input_stream[k] = 4'($urandom); if6.new_indices[k] = 3'($urandom);
        end
    endtask

    initial begin
        int e2 [2];
        int e8 [8];
        int e4 [4];
        int e6 [6];

        // Reset asserted with live random inputs: outputs must sit at zero with or without clock edges.
        rst_n = 1'b0;
        randomize_inputs();
        #1;
        check_reset("rst_async");
        repeat (3) @(negedge clk);
        randomize_inputs();
        @(negedge clk);
        check_reset("rst_clocked");

        rst_n = 1'b1;
        if8.in_valid = 1'b0; if4.in_valid = 1'b0; if6.in_valid = 1'b0;

        // SAMPLES=2 identity
        if2.in_valid     = 1'b1;
        if2.input_stream = '{3'd3, 3'd5};
        if2.new_indices  = '{1'd0, 1'd1};
        @(negedge clk);
        e2 = '{3, 5};
        check("id_valid", 32'(if2.out_valid), 1);
        for (int k = 0; k < 2; k++) check($sformatf("id_d%0d", k), 32'(if2.output_stream[k]), 32'(e2[k]));
        check("id_flags", 32'({if2.idx_range_err, if2.idx_perm_err}), 0);

        // SAMPLES=2 swap
        if2.new_indices = '{1'd1, 1'd0};
        @(negedge clk);
        e2 = '{5, 3};
        check("swap_valid", 32'(if2.out_valid), 1);
        for (int k = 0; k < 2; k++) check($sformatf("swap_d%0d", k), 32'(if2.output_stream[k]), 32'(e2[k]));

        // Drop in_valid with changed inputs: valid clears, data and flags hold.
        if2.in_valid     = 1'b0;
        if2.input_stream = '{3'd7, 3'd7};
        if2.new_indices  = '{1'd1, 1'd1};
        @(negedge clk);
        check("hold_valid", 32'(if2.out_valid), 0);
        for (int k = 0; k < 2; k++) check($sformatf("hold_d%0d", k), 32'(if2.output_stream[k]), 32'(e2[k]));
        check("hold_perm", 32'(if2.idx_perm_err), 0);

        // SAMPLES=8 bit-reversal
        if8.in_valid     = 1'b1;
        if8.input_stream = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17};
        if8.new_indices  = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
        @(negedge clk);
        if8.in_valid = 1'b0;
        e8 = '{10, 14, 12, 16, 11, 15, 13, 17};
        check("brev_valid", 32'(if8.out_valid), 1);
        for (int k = 0; k < 8; k++) check($sformatf("brev_d%0d", k), 32'(if8.output_stream[k]), 32'(e8[k]));
        check("brev_perm", 32'(if8.idx_perm_err), 0);
        check("brev_range", 32'(if8.idx_range_err), 0);

        // SAMPLES=4 duplicate index still gathers
        if4.in_valid     = 1'b1;
        if4.input_stream = '{4'd7, 4'd8, 4'd9, 4'd10};
        if4.new_indices  = '{2'd0, 2'd0, 2'd2, 2'd3};
        @(negedge clk);
        if4.in_valid = 1'b0;
        e4 = '{7, 7, 9, 10};
        check("dup_valid", 32'(if4.out_valid), 1);
        for (int k = 0; k < 4; k++) check($sformatf("dup_d%0d", k), 32'(if4.output_stream[k]), 32'(e4[k]));
        check("dup_perm", 32'(if4.idx_perm_err), 1);
        check("dup_range", 32'(if4.idx_range_err), 0);

        // SAMPLES=6 out-of-range slots zero; repeated out-of-range index is not a duplicate.
        if6.in_valid     = 1'b1;
        if6.input_stream = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        if6.new_indices  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7, 3'd7};
        @(negedge clk);
        e6 = '{1, 2, 3, 4, 0, 0};
        check("rng_valid", 32'(if6.out_valid), 1);
        for (int k = 0; k < 6; k++) check($sformatf("rng_d%0d", k), 32'(if6.output_stream[k]), 32'(e6[k]));
        check("rng_range", 32'(if6.idx_range_err), 1);
        check("rng_perm", 32'(if6.idx_perm_err), 0);

        // Three back-to-back beats, each seen one cycle after it is driven.
        if6.input_stream = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        if6.new_indices  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        @(negedge clk);
        e6 = '{1, 2, 3, 4, 5, 6};
        check("strA_valid", 32'(if6.out_valid), 1);
        for (int k = 0; k < 6; k++) check($sformatf("strA_d%0d", k), 32'(if6.output_stream[k]), 32'(e6[k]));
        check("strA_flags", 32'({if6.idx_range_err, if6.idx_perm_err}), 0);

        if6.input_stream = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        @(negedge clk);
        e6 = '{6, 5, 4, 3, 2, 1};
        check("strB_valid", 32'(if6.out_valid), 1);
        for (int k = 0; k < 6; k++) check($sformatf("strB_d%0d", k), 32'(if6.output_stream[k]), 32'(e6[k]));

        if6.input_stream = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4};
        if6.new_indices  = '{3'd5, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
        @(negedge clk);
        e6 = '{4, 4, 9, 8, 7, 6};
        check("strC_valid", 32'(if6.out_valid), 1);
        for (int k = 0; k < 6; k++) check($sformatf("strC_d%0d", k), 32'(if6.output_stream[k]), 32'(e6[k]));
        check("strC_perm", 32'(if6.idx_perm_err), 1);
        check("strC_range", 32'(if6.idx_range_err), 0);

        // Fourth beat captured, then reset lands mid-cycle: everything clears without a clock edge.
        if6.input_stream = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10};
        if6.new_indices  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        @(posedge clk);
        #2;
        check("strD_valid", 32'(if6.out_valid), 1);
        check("strD_d0", 32'(if6.output_stream[0]), 15);
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
